// File: rtl/memory_controller_pkg.sv
// Shared definitions for the LSB/ICache <-> memory controller interface.
// The LSB uses the same request direction and width codes.
package memory_controller_pkg;

  localparam logic       READ  = 1'b0;
  localparam logic       WRITE = 1'b1;

  localparam logic [2:0] W_BYTE = 3'd1;
  localparam logic [2:0] W_HALF = 3'd2;
  localparam logic [2:0] W_WORD = 3'd4;

  // addr[17:16] value that selects the memory-mapped IO region
  localparam logic [1:0] IO_REGION = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LSB_RD = 3'd1,
    LSB_WR = 3'd2,
    IC_RD  = 3'd3,
    DONE   = 3'd4
  } mc_state_e;

  // Any width code other than 1 or 2 is treated as a full word, so a
  // stray code can never leave the sequencer without a final byte.
  function automatic logic [2:0] norm_width(input logic [2:0] w);
    case (w)
      W_BYTE:  return W_BYTE;
      W_HALF:  return W_HALF;
      default: return W_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mc_byte_sequencer.sv
// Byte-serial engine: walks addr+k over the RAM bus, assembles read bytes
// little-endian, drives store bytes and holds on IO back-pressure.
module mc_byte_sequencer
  import memory_controller_pkg::*;
#(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [1:0] IO_ADDR_HI = IO_REGION
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  start,
  input  logic                  wr_req,
  input  logic [2:0]            width,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic                  rd_active,
  input  logic                  wr_active,
  input  logic                  io_full,
  input  logic [7:0]            mem_din,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [7:0]            mem_dout,
  output logic                  mem_wr,
  output logic [31:0]           data,
  output logic                  last
);

  logic [ADDR_WIDTH-1:0] base;
  logic [2:0]            n;
  logic [2:0]            cnt;   // bytes completed (read: captured, write: written)
  logic                  pend;  // mem_din this cycle carries byte cnt
  logic [3:0][7:0]       bytes;
  logic                  io_stall;

  assign io_stall = io_full && (base[17:16] == IO_ADDR_HI);
  assign mem_wr   = wr_active && rdy && !io_stall && (cnt < n);
  // While a sample is pending the bus is already one byte ahead.
  assign mem_a    = base + ADDR_WIDTH'(cnt) + ADDR_WIDTH'(pend);
  assign mem_dout = bytes[cnt[1:0]];
  assign data     = bytes;
  assign last     = (rd_active && rdy && pend && (cnt == n - 3'd1)) ||
                    (mem_wr && (cnt == n - 3'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      base  <= '0;
      n     <= '0;
      cnt   <= '0;
      pend  <= 1'b0;
      bytes <= '0;
    end else if (start) begin
      base  <= addr;
      n     <= width;
      cnt   <= '0;
      pend  <= 1'b0;
      bytes <= wr_req ? wdata : '0;
    end else if (rd_active) begin
      if (!rdy) begin
        // The in-flight sample is dropped; mem_a falls back to byte cnt,
        // which is re-issued on the first ready cycle.
        pend <= 1'b0;
      end else begin
        if (pend) begin
          bytes[cnt[1:0]] <= mem_din;
          cnt             <= cnt + 3'd1;
        end
        pend <= (cnt + {2'b00, pend}) < n;
      end
    end else if (mem_wr) begin
      cnt <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/memory_controller.sv
// Memory controller: arbitrates LSB over ICache, runs the request FSM and
// emits one-cycle completion pulses; byte traffic lives in the sequencer.
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [1:0] IO_ADDR_HI = IO_REGION
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst,
  input  logic                  Sys_rdy,
  input  logic                  LSBMC_en,
  input  logic                  LSBMC_wr,
  input  logic [2:0]            LSBMC_data_width,
  input  logic [31:0]           LSBMC_data,
  input  logic [ADDR_WIDTH-1:0] LSBMC_addr,
  output logic                  MCLSB_r_en,
  output logic                  MCLSB_w_en,
  output logic [31:0]           MCLSB_data,
  input  logic                  ICMC_en,
  input  logic [ADDR_WIDTH-1:0] ICMC_addr,
  output logic                  MCIC_en,
  output logic [31:0]           MCIC_data,
  input  logic                  RoBMC_pre_judge,
  input  logic                  io_buffer_full,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr
);

  mc_state_e             state, state_n;
  logic                  start, req_wr, seq_last;
  logic [2:0]            req_w;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_data, seq_data;
  logic                  r_pulse_n, w_pulse_n, ic_pulse_n;

  always_comb begin
    state_n    = state;
    start      = 1'b0;
    req_wr     = READ;
    req_w      = W_WORD;
    req_addr   = ICMC_addr;
    req_data   = '0;
    r_pulse_n  = 1'b0;
    w_pulse_n  = 1'b0;
    ic_pulse_n = 1'b0;
    if (Sys_rdy) begin
      case (state)
        IDLE: begin
          if (LSBMC_en) begin
            start    = 1'b1;
            req_wr   = LSBMC_wr;
            req_w    = norm_width(LSBMC_data_width);
            req_addr = LSBMC_addr;
            req_data = LSBMC_data;
            state_n  = (LSBMC_wr == WRITE) ? LSB_WR : LSB_RD;
          end else if (ICMC_en && RoBMC_pre_judge) begin
            start   = 1'b1;
            state_n = IC_RD;
          end
        end
        // A flush does not cut a load short: the LSB waits for its pulse.
        LSB_RD: if (seq_last) begin
          state_n   = DONE;
          r_pulse_n = 1'b1;
        end
        LSB_WR: if (seq_last) begin
          state_n   = DONE;
          w_pulse_n = 1'b1;
        end
        IC_RD: begin
          if (!RoBMC_pre_judge) begin
            state_n = IDLE;
          end else if (seq_last) begin
            state_n    = DONE;
            ic_pulse_n = 1'b1;
          end
        end
        // Requesters still hold en during the pulse cycle; ignore it here.
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      state      <= IDLE;
      MCLSB_r_en <= 1'b0;
      MCLSB_w_en <= 1'b0;
      MCIC_en    <= 1'b0;
    end else begin
      state      <= state_n;
      MCLSB_r_en <= r_pulse_n;
      MCLSB_w_en <= w_pulse_n;
      MCIC_en    <= ic_pulse_n;
    end
  end

  assign MCLSB_data = seq_data;
  assign MCIC_data  = seq_data;

  mc_byte_sequencer #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .IO_ADDR_HI(IO_ADDR_HI)
  ) u_seq (
    .clk      (Sys_clk),
    .rst      (Sys_rst),
    .rdy      (Sys_rdy),
    .start    (start),
    .wr_req   (req_wr),
    .width    (req_w),
    .addr     (req_addr),
    .wdata    (req_data),
    .rd_active((state == LSB_RD) || (state == IC_RD)),
    .wr_active(state == LSB_WR),
    .io_full  (io_buffer_full),
    .mem_din  (mem_din),
    .mem_a    (mem_a),
    .mem_dout (mem_dout),
    .mem_wr   (mem_wr),
    .data     (seq_data),
    .last     (seq_last)
  );

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: byte RAM model on the bus, cycle-exact
// checks of addresses, strobes, completion pulses and assembled data.
module tb_memory_controller;

  logic        clk = 1'b0;
  logic        Sys_rst, Sys_rdy;
  logic        LSBMC_en, LSBMC_wr;
  logic [2:0]  LSBMC_data_width;
  logic [31:0] LSBMC_data, LSBMC_addr;
  logic        MCLSB_r_en, MCLSB_w_en;
  logic [31:0] MCLSB_data;
  logic        ICMC_en;
  logic [31:0] ICMC_addr;
  logic        MCIC_en;
  logic [31:0] MCIC_data;
  logic        RoBMC_pre_judge, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int checks = 0;
  int failures = 0;

  logic [7:0] ram [0:262143];

  always #5 clk = ~clk;

  memory_controller dut (
    .Sys_clk(clk), .Sys_rst(Sys_rst), .Sys_rdy(Sys_rdy),
    .LSBMC_en(LSBMC_en), .LSBMC_wr(LSBMC_wr), .LSBMC_data_width(LSBMC_data_width),
    .LSBMC_data(LSBMC_data), .LSBMC_addr(LSBMC_addr),
    .MCLSB_r_en(MCLSB_r_en), .MCLSB_w_en(MCLSB_w_en), .MCLSB_data(MCLSB_data),
    .ICMC_en(ICMC_en), .ICMC_addr(ICMC_addr), .MCIC_en(MCIC_en), .MCIC_data(MCIC_data),
    .RoBMC_pre_judge(RoBMC_pre_judge), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  // RAM: read data appears one cycle after the address
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    mem_din <= ram[mem_a[17:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic lsb(input logic wr, input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
    LSBMC_en = 1'b1; LSBMC_wr = wr; LSBMC_data_width = w; LSBMC_addr = a; LSBMC_data = d;
  endtask

  // Load of w bytes; pulse expected exactly w+2 cycles after acceptance.
  task automatic lsb_load(input logic [2:0] w, input logic [31:0] a, input logic [31:0] exp, input string tag);
    lsb(1'b0, w, a, 32'h0);
    repeat (int'(w) + 2) tick();
    chk({tag, "_pulse"}, {31'h0, MCLSB_r_en}, 32'h1);
    chk({tag, "_data"}, MCLSB_data, exp);
    LSBMC_en = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    int nic, npulse, pcyc, nwr, n;
    logic [31:0] pdata;
    ram[18'h00100] <= 8'h11; ram[18'h00101] <= 8'h22;
    ram[18'h00102] <= 8'h33; ram[18'h00103] <= 8'h44;
    ram[18'h00010] <= 8'h5A;
    ram[18'h00400] <= 8'h13; ram[18'h00401] <= 8'h05;
    ram[18'h00402] <= 8'h00; ram[18'h00403] <= 8'h00;
    ram[18'h3FFFF] <= 8'h99; ram[18'h00000] <= 8'h88;
    ram[18'h00500] <= 8'h00; ram[18'h00501] <= 8'h00;
    ram[18'h00502] <= 8'h00; ram[18'h00503] <= 8'h00;
    Sys_rst = 1'b1; Sys_rdy = 1'b1; RoBMC_pre_judge = 1'b1; io_buffer_full = 1'b0;
    LSBMC_en = 1'b0; LSBMC_wr = 1'b0; LSBMC_data_width = 3'd0; LSBMC_data = '0; LSBMC_addr = '0;
    ICMC_en = 1'b0; ICMC_addr = '0;
    tick();
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("rst_pulses", {29'h0, MCLSB_r_en, MCLSB_w_en, MCIC_en}, 32'h0);
    chk("rst_data", MCLSB_data, 32'h0);
    Sys_rst = 1'b0;
    tick();

    // lw 0x100
    lsb(1'b0, 3'd4, 32'h100, 32'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("lw_mem_a", mem_a, 32'h100 + k);
      chk("lw_mem_wr", {31'h0, mem_wr}, 32'h0);
      tick();
    end
    chk("lw_no_early_pulse", {31'h0, MCLSB_r_en}, 32'h0);
    tick();
    chk("lw_pulse", {31'h0, MCLSB_r_en}, 32'h1);
    chk("lw_data", MCLSB_data, 32'h44332211);
    LSBMC_en = 1'b0;
    tick();

    // sh 0x200 <- 0xABCD
    lsb(1'b1, 3'd2, 32'h200, 32'h0000ABCD);
    tick();
    chk("sh_b0", {mem_wr, 15'h0, mem_dout, mem_a[7:0]}, {1'b1, 15'h0, 8'hCD, 8'h00});
    chk("sh_b0_addr", mem_a, 32'h200);
    tick();
    chk("sh_b1", {mem_wr, 15'h0, mem_dout, mem_a[7:0]}, {1'b1, 15'h0, 8'hAB, 8'h01});
    tick();
    chk("sh_pulse", {30'h0, MCLSB_w_en, mem_wr}, 32'h2);
    LSBMC_en = 1'b0;
    tick();
    lsb_load(3'd2, 32'h200, 32'h0000ABCD, "sh_readback");

    // LSB lb and IC fetch raised together
    ICMC_en = 1'b1; ICMC_addr = 32'h400;
    lsb(1'b0, 3'd1, 32'h10, 32'h0);
    tick();
    chk("prio_mem_a", mem_a, 32'h10);
    tick(); tick();
    chk("prio_lsb_pulse", {30'h0, MCLSB_r_en, MCIC_en}, 32'h2);
    chk("prio_lb_zext", MCLSB_data, 32'h0000005A);
    LSBMC_en = 1'b0;
    tick();
    chk("prio_idle_no_fetch_addr", {31'h0, MCIC_en}, 32'h0);
    tick();
    chk("fetch_mem_a", mem_a, 32'h400);
    repeat (5) tick();
    chk("fetch_pulse", {31'h0, MCIC_en}, 32'h1);
    chk("fetch_data", MCIC_data, 32'h00000513);
    ICMC_en = 1'b0;
    tick();

    // flush during IC_RD at byte 2
    ICMC_en = 1'b1; ICMC_addr = 32'h400;
    tick(); tick(); tick();
    chk("icflush_byte2_addr", mem_a, 32'h402);
    RoBMC_pre_judge = 1'b0; ICMC_en = 1'b0;
    tick();
    RoBMC_pre_judge = 1'b1;
    nic = int'(MCIC_en);
    lsb(1'b0, 3'd1, 32'h10, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      nic += int'(MCIC_en);
    end
    chk("icflush_no_pulse", nic, 0);
    chk("icflush_idle_then_lb", {31'h0, MCLSB_r_en}, 32'h1);
    chk("icflush_lb_data", MCLSB_data, 32'h5A);
    LSBMC_en = 1'b0;
    tick();

    // flush during LSB_RD still yields exactly one pulse on time
    lsb(1'b0, 3'd4, 32'h100, 32'h0);
    tick(); tick(); tick();
    RoBMC_pre_judge = 1'b0;
    tick();
    RoBMC_pre_judge = 1'b1;
    npulse = 0; pcyc = -1; pdata = '0;
    for (int i = 4; i <= 10; i++) begin
      if (MCLSB_r_en) begin npulse++; pcyc = i; pdata = MCLSB_data; end
      if (i == 6) LSBMC_en = 1'b0;
      tick();
    end
    chk("lsbflush_one_pulse", npulse, 1);
    chk("lsbflush_pulse_cycle", pcyc, 6);
    chk("lsbflush_data", pdata, 32'h44332211);

    // sb to IO region under back-pressure
    io_buffer_full = 1'b1;
    lsb(1'b1, 3'd1, 32'h00030000, 32'hFFFFFF77);
    tick();
    nwr = 0;
    for (int i = 0; i < 3; i++) begin
      nwr += int'(mem_wr);
      tick();
    end
    chk("io_hold_no_wr", nwr, 0);
    io_buffer_full = 1'b0;
    #1;
    chk("io_release_wr", {mem_wr, 23'h0, mem_dout}, {1'b1, 23'h0, 8'h77});
    chk("io_release_addr", mem_a, 32'h00030000);
    tick();
    chk("io_pulse", {30'h0, MCLSB_w_en, mem_wr}, 32'h2);
    LSBMC_en = 1'b0;
    tick();
    lsb_load(3'd1, 32'h00030000, 32'h77, "io_readback");

    // address wrap at 2^32
    lsb(1'b0, 3'd2, 32'hFFFFFFFF, 32'h0);
    tick();
    chk("wrap_a0", mem_a, 32'hFFFFFFFF);
    tick();
    chk("wrap_a1", mem_a, 32'h0);
    tick(); tick();
    chk("wrap_pulse", {31'h0, MCLSB_r_en}, 32'h1);
    chk("wrap_data", MCLSB_data, 32'h00008899);
    LSBMC_en = 1'b0;
    tick();

    // Sys_rdy low for two cycles mid-read
    lsb(1'b0, 3'd4, 32'h100, 32'h0);
    tick(); tick(); tick();
    Sys_rdy = 1'b0;
    tick(); tick();
    Sys_rdy = 1'b1;
    #1;
    chk("rdy_reissue_addr", mem_a, 32'h101);
    n = 0;
    while (!MCLSB_r_en && n < 20) begin
      tick();
      n++;
    end
    chk("rdy_pulse", {31'h0, MCLSB_r_en}, 32'h1);
    chk("rdy_data", MCLSB_data, 32'h44332211);
    LSBMC_en = 1'b0;
    tick();

    // reset in the middle of a sw
    lsb(1'b1, 3'd4, 32'h500, 32'hDEADBEEF);
    tick();
    chk("rstw_b0", {mem_wr, 23'h0, mem_dout}, {1'b1, 23'h0, 8'hEF});
    tick();
    Sys_rst = 1'b1;
    tick();
    chk("rstw_mem", {mem_wr, 15'h0, mem_dout, 8'h0}, 32'h0);
    chk("rstw_mem_a", mem_a, 32'h0);
    chk("rstw_pulses", {29'h0, MCLSB_r_en, MCLSB_w_en, MCIC_en}, 32'h0);
    chk("rstw_data", MCLSB_data | MCIC_data, 32'h0);
    Sys_rst = 1'b0; LSBMC_en = 1'b0;
    npulse = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      npulse += int'(MCLSB_w_en);
    end
    chk("rstw_no_pulse", npulse, 0);
    lsb_load(3'd4, 32'h500, 32'h0000BEEF, "rstw_partial");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
